// File: rtl/alu_pkg.sv
// alu_pkg: shared condition codes, flag bit positions and stage states
package alu_pkg;
    typedef enum logic [3:0] {
        C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
        C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
    } cond_e;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef enum logic [1:0] {EMPTY, LO, HI} stage_state_e;
endpackage

// File: rtl/alu_cond_stage_if.sv
// alu_cond_stage_if: upstream beat, writeback beat and flag bundle of the stage
interface alu_cond_stage_if #(
    parameter int N          = 16,
    parameter int REG_ADDR_W = 4
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [2*N-1:0]        alu_result;
    logic [3:0]            alu_flags;
    logic [3:0]            cond;
    logic                  set_flags;
    logic                  rd_we;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  is_mul;
    logic                  out_valid;
    logic                  out_ready;
    logic [N-1:0]          out_data;
    logic [REG_ADDR_W-1:0] out_rd_addr;
    logic                  out_reg_we;
    logic [3:0]            flags_q;
    modport master (
        output flush, in_valid, alu_result, alu_flags, cond, set_flags, rd_we, rd_addr, is_mul, out_ready,
        input  in_ready, out_valid, out_data, out_rd_addr, out_reg_we, flags_q
    );
    modport slave (
        input  flush, in_valid, alu_result, alu_flags, cond, set_flags, rd_we, rd_addr, is_mul, out_ready,
        output in_ready, out_valid, out_data, out_rd_addr, out_reg_we, flags_q
    );
endinterface

// File: rtl/alu_cond_stage_cond_check.sv
// cond_check: evaluates an ARM condition code against {N,Z,C,V}
module cond_check
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic n, z, c, v;
    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];
    // Decode the condition; the reserved encoding never passes
    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            C_EQ:    pass = z;
            C_NE:    pass = !z;
            C_CS:    pass = c;
            C_CC:    pass = !c;
            C_MI:    pass = n;
            C_PL:    pass = !n;
            C_VS:    pass = v;
            C_VC:    pass = !v;
            C_HI:    pass = c & !z;
            C_LS:    pass = !c | z;
            C_GE:    pass = n == v;
            C_LT:    pass = n != v;
            C_GT:    pass = !z & (n == v);
            C_LE:    pass = z | (n != v);
            C_AL:    pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_cond_stage.sv
// alu_cond_stage: registers ALU results, applies condition codes and splits MUL writebacks
module alu_cond_stage
    import alu_pkg::*;
#(
    parameter int N          = 16,
    parameter int REG_ADDR_W = 4
) (
    input logic              clk,
    input logic              rst,
    alu_cond_stage_if.slave  bus
);
    stage_state_e          state_q, state_d;
    logic [2*N-1:0]        res_q, res_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  rd_we_q, rd_we_d;
    logic                  mul_q, mul_d;
    logic [3:0]            flags_q, flags_d;
    logic                  pass, load;

    cond_check u_cond (
        .cond  (bus.cond),
        .flags (flags_q),
        .pass  (pass)
    );

    assign bus.in_ready = !bus.flush & ((state_q == EMPTY) |
                          (state_q == LO & !mul_q & bus.out_ready) |
                          (state_q == HI & bus.out_ready));
    assign load = bus.in_valid & bus.in_ready & pass;

    assign bus.out_valid   = state_q != EMPTY;
    assign bus.out_data    = state_q == HI ? res_q[2*N-1:N] : state_q == LO ? res_q[N-1:0] : '0;
    assign bus.out_rd_addr = state_q == HI ? rd_q + REG_ADDR_W'(1) : state_q == LO ? rd_q : '0;
    assign bus.out_reg_we  = (state_q != EMPTY) & rd_we_q;
    assign bus.flags_q     = flags_q;

    // Next state and beat capture; a flush discards any pending half
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        rd_d    = rd_q;
        rd_we_d = rd_we_q;
        mul_d   = mul_q;
        flags_d = flags_q;
        if (load) begin
            res_d   = bus.alu_result;
            rd_d    = bus.rd_addr;
            rd_we_d = bus.rd_we;
            mul_d   = bus.is_mul;
            flags_d = bus.set_flags ? bus.alu_flags : flags_q;
        end
        case (state_q)
            EMPTY:   state_d = load ? LO : EMPTY;
            LO:      state_d = !bus.out_ready ? LO : mul_q ? HI : load ? LO : EMPTY;
            HI:      state_d = !bus.out_ready ? HI : load ? LO : EMPTY;
            default: state_d = EMPTY;
        endcase
        if (bus.flush) state_d = EMPTY;
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            res_q   <= '0;
            rd_q    <= '0;
            rd_we_q <= 1'b0;
            mul_q   <= 1'b0;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
            rd_we_q <= rd_we_d;
            mul_q   <= mul_d;
            flags_q <= flags_d;
        end
    end
endmodule

// File: tb/tb_alu_cond_stage.sv
// tb_alu_cond_stage: per-cycle directed vector table plus a flush-priority sequence
module tb_alu_cond_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_cond_stage_if #(.N(16), .REG_ADDR_W(4)) bus ();

    alu_cond_stage #(.N(16), .REG_ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        rst, flush, iv;
        logic [31:0] res;
        logic [3:0]  flg, cond;
        logic        sf, we;
        logic [3:0]  rd;
        logic        mul, ordy;
        logic        e_ir, e_ov;
        logic [15:0] e_d;
        logic [3:0]  e_a;
        logic        e_we;
        logic [3:0]  e_f;
    } vec_t;

    vec_t tbl [29];

    function automatic vec_t mk(input int r, fl, iv, res, flg, cnd, sf, we, rd, mul, ordy,
                                input int ir, ov, d, a, ewe, f);
        vec_t x;
        x.rst = 1'(r); x.flush = 1'(fl); x.iv = 1'(iv); x.res = 32'(res);
        x.flg = 4'(flg); x.cond = 4'(cnd); x.sf = 1'(sf); x.we = 1'(we);
        x.rd = 4'(rd); x.mul = 1'(mul); x.ordy = 1'(ordy);
        x.e_ir = 1'(ir); x.e_ov = 1'(ov); x.e_d = 16'(d); x.e_a = 4'(a);
        x.e_we = 1'(ewe); x.e_f = 4'(f);
        return x;
    endfunction

    function automatic vec_t idle(input int ir, ov, d, a, ewe, f);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ir, ov, d, a, ewe, f);
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        rst            = x.rst;
        bus.flush      = x.flush;
        bus.in_valid   = x.iv;
        bus.alu_result = x.res;
        bus.alu_flags  = x.flg;
        bus.cond       = x.cond;
        bus.set_flags  = x.sf;
        bus.rd_we      = x.we;
        bus.rd_addr    = x.rd;
        bus.is_mul     = x.mul;
        bus.out_ready  = x.ordy;
    endtask

    initial begin
        tbl[0]  = idle(1, 0, 0, 0, 0, 4'h0);
        tbl[1]  = mk(0, 0, 1, 32'h0, 4'b0100, 4'hE, 1, 1, 3, 0, 1, 1, 0, 0, 0, 0, 4'h0);
        tbl[2]  = mk(0, 0, 1, 32'h55, 0, 4'h0, 0, 1, 5, 0, 1, 1, 1, 16'h0000, 3, 1, 4'b0100);
        tbl[3]  = mk(0, 0, 1, 32'h77, 4'hF, 4'h1, 1, 1, 6, 0, 1, 1, 1, 16'h0055, 5, 1, 4'b0100);
        tbl[4]  = idle(1, 0, 0, 0, 0, 4'b0100);
        tbl[5]  = mk(0, 0, 1, 32'h1234ABCD, 0, 4'hE, 0, 1, 15, 1, 1, 1, 0, 0, 0, 0, 4'b0100);
        tbl[6]  = mk(0, 0, 1, 32'h99, 0, 4'hE, 0, 1, 2, 0, 1, 0, 1, 16'hABCD, 15, 1, 4'b0100);
        tbl[7]  = mk(0, 0, 1, 32'h99, 0, 4'hE, 0, 1, 2, 0, 1, 1, 1, 16'h1234, 0, 1, 4'b0100);
        tbl[8]  = idle(1, 1, 16'h0099, 2, 1, 4'b0100);
        tbl[9]  = mk(0, 0, 1, 32'h42, 4'b1000, 4'hE, 1, 0, 7, 0, 0, 1, 0, 0, 0, 0, 4'b0100);
        tbl[10] = mk(0, 0, 1, 32'h11, 0, 4'hE, 0, 1, 8, 0, 0, 0, 1, 16'h0042, 7, 0, 4'b1000);
        tbl[11] = tbl[10];
        tbl[12] = tbl[10];
        tbl[13] = mk(0, 0, 1, 32'h11, 0, 4'hE, 0, 1, 8, 0, 1, 1, 1, 16'h0042, 7, 0, 4'b1000);
        tbl[14] = idle(1, 1, 16'h0011, 8, 1, 4'b1000);
        tbl[15] = mk(0, 0, 1, 32'hBEEFCAFE, 0, 4'hE, 0, 1, 9, 1, 1, 1, 0, 0, 0, 0, 4'b1000);
        tbl[16] = idle(0, 1, 16'hCAFE, 9, 1, 4'b1000);
        tbl[17] = mk(0, 1, 1, 32'h33, 4'b0001, 4'hE, 1, 1, 4, 0, 0, 0, 1, 16'hBEEF, 10, 1, 4'b1000);
        tbl[18] = idle(1, 0, 0, 0, 0, 4'b1000);
        tbl[19] = mk(0, 0, 1, 32'h1111, 4'b0011, 4'hB, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 4'b1000);
        tbl[20] = mk(0, 0, 1, 32'h2222, 0, 4'hC, 0, 1, 2, 0, 1, 1, 1, 16'h1111, 1, 1, 4'b0011);
        tbl[21] = mk(0, 0, 1, 32'h3333, 0, 4'hD, 0, 1, 3, 0, 1, 1, 0, 0, 0, 0, 4'b0011);
        tbl[22] = mk(0, 0, 1, 32'h4444, 0, 4'h8, 0, 1, 4, 0, 1, 1, 1, 16'h3333, 3, 1, 4'b0011);
        tbl[23] = mk(0, 0, 1, 32'h5555, 0, 4'hF, 0, 1, 5, 0, 1, 1, 1, 16'h4444, 4, 1, 4'b0011);
        tbl[24] = mk(0, 0, 1, 32'hFFFF6666, 0, 4'h2, 0, 0, 6, 0, 1, 1, 0, 0, 0, 0, 4'b0011);
        tbl[25] = idle(1, 1, 16'h6666, 6, 0, 4'b0011);
        tbl[26] = mk(0, 0, 1, 32'hA5A55A5A, 4'hF, 4'hE, 1, 1, 12, 1, 1, 1, 0, 0, 0, 0, 4'b0011);
        tbl[27] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h5A5A, 12, 1, 4'hF);
        tbl[28] = idle(1, 0, 0, 0, 0, 4'h0);

        drive(idle(0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk("in_ready",    i, 32'(bus.in_ready),    32'(tbl[i].e_ir));
            chk("out_valid",   i, 32'(bus.out_valid),   32'(tbl[i].e_ov));
            chk("out_data",    i, 32'(bus.out_data),    32'(tbl[i].e_d));
            chk("out_rd_addr", i, 32'(bus.out_rd_addr), 32'(tbl[i].e_a));
            chk("out_reg_we",  i, 32'(bus.out_reg_we),  32'(tbl[i].e_we));
            chk("flags_q",     i, 32'(bus.flags_q),     32'(tbl[i].e_f));
        end

        @(negedge clk);
        drive(mk(0, 1, 1, 32'h1, 4'b0110, 4'hE, 1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0));
        #1;
        chk("flush_in_ready", 29, 32'(bus.in_ready), 32'h0);
        @(negedge clk);
        drive(idle(0, 0, 0, 0, 0, 0));
        #1;
        chk("flush_no_accept", 30, 32'(bus.out_valid), 32'h0);
        chk("flush_no_flags",  30, 32'(bus.flags_q),   32'h0);
        chk("flush_ready_back", 30, 32'(bus.in_ready), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
